dma_seq: RTL and testbench

Transfer sequencer for the DMA path: on a start command it moves a run of SDRAM bursts into on-chip buffer mem1 or mem2. It generates the clear/init/add strobes consumed by the DMA address generator (SDRAM address +4 per add, buffer address +16 per add, 6-bit buffer wrap) and runs the SDRAM read request/acknowledge handshake. It sits between the layer control logic (start/busy/done) and the address generator plus SDRAM port.

---
 rtl/dma_seq_if.sv | 41 ++++
 rtl/dma_seq.sv | 137 +++++++++++++
 tb/tb_dma_seq.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/dma_seq_if.sv
// Signal bundle between the DMA transfer sequencer and its environment
// (layer control, DMA address generator, SDRAM read port).
interface dma_seq_if;
  logic       start;
  logic       dir;
  logic [7:0] base_sdram;
  logic [5:0] base_mem;
  logic [3:0] num_bursts;
  logic       abort;
  logic       sdram_rd_ack;

  logic       sdram_rd_req;
  logic       mem1_we;
  logic       mem2_we;
  logic [7:0] latch_sdram_addr;
  logic [5:0] latch_mem_addr;
  logic       clear_addr;
  logic       init_sdram_addr;
  logic       init_mem1_addr;
  logic       init_mem2_addr;
  logic       add_sdram_addr;
  logic       add_mem1_addr;
  logic       add_mem2_addr;
  logic       busy;
  logic       done;
  logic       timeout_err;

  modport master (
    input  start, dir, base_sdram, base_mem, num_bursts, abort, sdram_rd_ack,
    output sdram_rd_req, mem1_we, mem2_we, latch_sdram_addr, latch_mem_addr,
           clear_addr, init_sdram_addr, init_mem1_addr, init_mem2_addr,
           add_sdram_addr, add_mem1_addr, add_mem2_addr, busy, done, timeout_err
  );

  modport slave (
    output start, dir, base_sdram, base_mem, num_bursts, abort, sdram_rd_ack,
    input  sdram_rd_req, mem1_we, mem2_we, latch_sdram_addr, latch_mem_addr,
           clear_addr, init_sdram_addr, init_mem1_addr, init_mem2_addr,
           add_sdram_addr, add_mem1_addr, add_mem2_addr, busy, done, timeout_err
  );
endinterface

// File: rtl/dma_seq.sv
// DMA transfer sequencer: moves a run of SDRAM bursts into mem1/mem2 by
// strobing the address generator and handshaking SDRAM read requests.
module dma_seq #(
  parameter int unsigned TIMEOUT = 255
) (
  input logic       clk_h,
  input logic       rst_n,
  dma_seq_if.master bus
);

  typedef enum logic [3:0] {
    StIdle, StClear, StInitSd, StInitMem, StReq, StWrite, StAdvSd, StAdvMem, StDone
  } state_e;

  // Last wait-counter value before a missing ack becomes a timeout.
  localparam logic [7:0] WaitLast = 8'(TIMEOUT - 1);

  state_e     state_q, state_d;
  logic       dir_q, dir_d;
  logic [3:0] rem_q, rem_d;
  logic [7:0] wait_q, wait_d;
  logic       tmo_q, tmo_d;
  logic [7:0] lsd_q, lsd_d;
  logic [5:0] lmem_q, lmem_d;

  always_ff @(posedge clk_h) begin
    if (!rst_n) begin
      state_q <= StIdle;
      dir_q   <= 1'b0;
      rem_q   <= 4'd0;
      wait_q  <= 8'd0;
      tmo_q   <= 1'b0;
      lsd_q   <= 8'd0;
      lmem_q  <= 6'd0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      rem_q   <= rem_d;
      wait_q  <= wait_d;
      tmo_q   <= tmo_d;
      lsd_q   <= lsd_d;
      lmem_q  <= lmem_d;
    end
  end

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    rem_d   = rem_q;
    wait_d  = wait_q;
    tmo_d   = tmo_q;
    lsd_d   = lsd_q;
    lmem_d  = lmem_q;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          dir_d   = bus.dir;
          lsd_d   = bus.base_sdram;
          lmem_d  = bus.base_mem;
          rem_d   = bus.num_bursts;
          tmo_d   = 1'b0;
          state_d = StClear;
        end
      end
      StClear:   state_d = StInitSd;
      StInitSd:  state_d = StInitMem;
      StInitMem: begin
        wait_d  = 8'd0;
        state_d = (rem_q == 4'd0) ? StDone : StReq;
      end
      StReq: begin
        if (bus.sdram_rd_ack) begin
          state_d = StWrite;
        end else if (wait_q == WaitLast) begin
          tmo_d   = 1'b1;
          state_d = StIdle;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      StWrite:  state_d = StAdvSd;
      StAdvSd:  state_d = StAdvMem;
      StAdvMem: begin
        rem_d   = rem_q - 4'd1;
        wait_d  = 8'd0;
        state_d = (rem_q == 4'd1) ? StDone : StReq;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    // Abort overrides everything, including a same-cycle ack or timeout.
    if (bus.abort && (state_q != StIdle)) begin
      state_d = StIdle;
      tmo_d   = tmo_q;
    end
  end

  always_comb begin
    bus.sdram_rd_req    = 1'b0;
    bus.mem1_we         = 1'b0;
    bus.mem2_we         = 1'b0;
    bus.clear_addr      = 1'b0;
    bus.init_sdram_addr = 1'b0;
    bus.init_mem1_addr  = 1'b0;
    bus.init_mem2_addr  = 1'b0;
    bus.add_sdram_addr  = 1'b0;
    bus.add_mem1_addr   = 1'b0;
    bus.add_mem2_addr   = 1'b0;
    bus.done            = 1'b0;
    unique case (state_q)
      StClear:   bus.clear_addr = 1'b1;
      StInitSd:  bus.init_sdram_addr = 1'b1;
      StInitMem: begin
        bus.init_mem1_addr = ~dir_q;
        bus.init_mem2_addr = dir_q;
      end
      StReq:     bus.sdram_rd_req = 1'b1;
      StWrite: begin
        bus.mem1_we = ~dir_q;
        bus.mem2_we = dir_q;
      end
      StAdvSd:   bus.add_sdram_addr = 1'b1;
      StAdvMem: begin
        bus.add_mem1_addr = ~dir_q;
        bus.add_mem2_addr = dir_q;
      end
      StDone:    bus.done = 1'b1;
      default:   ;
    endcase
  end

  assign bus.busy             = (state_q != StIdle);
  assign bus.timeout_err      = tmo_q;
  assign bus.latch_sdram_addr = lsd_q;
  assign bus.latch_mem_addr   = lmem_q;

endmodule

// File: tb/tb_dma_seq.sv
// Bench for dma_seq: builds the expected per-cycle output trace of each
// transfer from the sequencing rules and compares it cycle by cycle.
module tb_dma_seq;

  localparam int unsigned Tmo = 8;

  localparam logic [11:0] ReqBit  = 12'h800;
  localparam logic [11:0] We1Bit  = 12'h400;
  localparam logic [11:0] We2Bit  = 12'h200;
  localparam logic [11:0] ClrBit  = 12'h100;
  localparam logic [11:0] IsdBit  = 12'h080;
  localparam logic [11:0] Im1Bit  = 12'h040;
  localparam logic [11:0] Im2Bit  = 12'h020;
  localparam logic [11:0] AsdBit  = 12'h010;
  localparam logic [11:0] Am1Bit  = 12'h008;
  localparam logic [11:0] Am2Bit  = 12'h004;
  localparam logic [11:0] BusyBit = 12'h002;
  localparam logic [11:0] DoneBit = 12'h001;

  typedef struct {
    logic [11:0] vec;
    bit          ack;
    bit          abort;
  } ent_t;

  logic clk_h = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail = 0;
  int   dl[16];
  ent_t tr[$];

  dma_seq_if bus();

  dma_seq #(.TIMEOUT(Tmo)) u_dut (
    .clk_h (clk_h),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk_h = ~clk_h;

  logic [11:0] obs_vec;
  logic [6:0]  strobes;
  assign strobes = {bus.clear_addr, bus.init_sdram_addr, bus.init_mem1_addr, bus.init_mem2_addr,
                    bus.add_sdram_addr, bus.add_mem1_addr, bus.add_mem2_addr};
  assign obs_vec = {bus.sdram_rd_req, bus.mem1_we, bus.mem2_we, strobes, bus.busy, bus.done};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_h);
    #1;
  endtask

  task automatic rand_cmd();
    bus.start      = 1'($urandom_range(0, 1));
    bus.dir        = 1'($urandom_range(0, 1));
    bus.base_sdram = 8'($urandom);
    bus.base_mem   = 6'($urandom);
    bus.num_bursts = 4'($urandom);
  endtask

  // One transfer: d/bsd/bm/n are the command, dl[] the ack delay per burst,
  // abort_b the burst whose first REQ cycle sees abort together with ack (-1: none).
  task automatic run_xfer(input bit d, input logic [7:0] bsd, input logic [5:0] bm,
                          input int n, input int abort_b);
    ent_t e;
    bit   timed_out = 0;
    bit   aborted = 0;
    int   exp_done = 4;
    int   done_cyc = -1;
    bit   exp_tmo;

    tr.delete();
    e.abort = 0;
    e.ack = 1'($urandom_range(0, 1)); e.vec = ClrBit | BusyBit; tr.push_back(e);
    e.ack = 1'($urandom_range(0, 1)); e.vec = IsdBit | BusyBit; tr.push_back(e);
    e.ack = 1'($urandom_range(0, 1)); e.vec = (d ? Im2Bit : Im1Bit) | BusyBit; tr.push_back(e);
    for (int i = 0; i < n; i++) begin
      if (i == abort_b) begin
        e.vec = ReqBit | BusyBit; e.ack = 1; e.abort = 1; tr.push_back(e);
        aborted = 1;
        break;
      end
      if (dl[i] >= int'(Tmo)) begin
        for (int j = 0; j < int'(Tmo); j++) begin
          e.vec = ReqBit | BusyBit; e.ack = 0; tr.push_back(e);
        end
        timed_out = 1;
        break;
      end
      for (int j = 0; j < dl[i]; j++) begin
        e.vec = ReqBit | BusyBit; e.ack = 0; tr.push_back(e);
      end
      e.vec = ReqBit | BusyBit; e.ack = 1; tr.push_back(e);
      e.ack = 1'($urandom_range(0, 1)); e.vec = (d ? We2Bit : We1Bit) | BusyBit; tr.push_back(e);
      e.ack = 1'($urandom_range(0, 1)); e.vec = AsdBit | BusyBit; tr.push_back(e);
      e.ack = 1'($urandom_range(0, 1)); e.vec = (d ? Am2Bit : Am1Bit) | BusyBit; tr.push_back(e);
      exp_done += 4 + dl[i];
    end
    if (!timed_out && !aborted) begin
      e.ack = 1'($urandom_range(0, 1)); e.vec = DoneBit | BusyBit; tr.push_back(e);
    end else begin
      exp_done = -1;
    end
    exp_tmo = timed_out;

    bus.start        = 1'b1;
    bus.dir          = d;
    bus.base_sdram   = bsd;
    bus.base_mem     = bm;
    bus.num_bursts   = 4'(n);
    bus.abort        = 1'($urandom_range(0, 1));
    bus.sdram_rd_ack = 1'($urandom_range(0, 1));
    step();
    foreach (tr[k]) begin
      chk("outputs", 32'(obs_vec), 32'(tr[k].vec));
      chk("one_strobe", 32'($countones(strobes) <= 1), 32'd1);
      chk("latch_sdram", 32'(bus.latch_sdram_addr), 32'(bsd));
      chk("latch_mem", 32'(bus.latch_mem_addr), 32'(bm));
      chk("tmo_in_run", 32'(bus.timeout_err), 32'd0);
      if (bus.done && done_cyc < 0) done_cyc = k + 1;
      rand_cmd();
      bus.sdram_rd_ack = tr[k].ack;
      bus.abort        = tr[k].abort;
      step();
    end
    bus.start = 1'b0; bus.abort = 1'b0; bus.sdram_rd_ack = 1'b0;
    chk("idle_after", 32'(obs_vec), 32'd0);
    chk("tmo_after", 32'(bus.timeout_err), 32'(exp_tmo));
    chk("latch_held", 32'({bus.latch_sdram_addr, bus.latch_mem_addr}), 32'({bsd, bm}));
    chk("done_cycle", 32'(done_cyc), 32'(exp_done));
    step();
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, ab;
    bus.start = 0; bus.dir = 0; bus.base_sdram = 0; bus.base_mem = 0;
    bus.num_bursts = 0; bus.abort = 0; bus.sdram_rd_ack = 0;
    foreach (dl[i]) dl[i] = 0;
    rst_n = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;

    // Idle with abort/ack noise: nothing moves.
    for (int i = 0; i < 10; i++) begin
      chk("reset_idle", 32'(obs_vec), 32'd0);
      chk("reset_latch", 32'({bus.latch_sdram_addr, bus.latch_mem_addr}), 32'd0);
      chk("reset_tmo", 32'(bus.timeout_err), 32'd0);
      bus.abort = 1'($urandom_range(0, 1));
      bus.sdram_rd_ack = 1'($urandom_range(0, 1));
      step();
    end
    bus.abort = 0; bus.sdram_rd_ack = 0;

    // Directed: mem1, three immediate bursts.
    run_xfer(1'b0, 8'h10, 6'h02, 3, -1);
    // mem2, two bursts each acked after 5 wait cycles.
    dl[0] = 5; dl[1] = 5;
    run_xfer(1'b1, 8'h20, 6'h11, 2, -1);
    // Zero bursts.
    run_xfer(1'b0, 8'h33, 6'h3f, 0, -1);
    // Ack never comes: timeout on first burst.
    dl[0] = Tmo;
    run_xfer(1'b1, 8'h44, 6'h05, 3, -1);
    // Ack on the last permissible cycle, then timeout on a later burst.
    dl[0] = Tmo - 1; dl[1] = 0; dl[2] = Tmo;
    run_xfer(1'b0, 8'h55, 6'h07, 4, -1);
    // Abort coinciding with ack in the second burst.
    foreach (dl[i]) dl[i] = 0;
    run_xfer(1'b0, 8'h66, 6'h09, 3, 1);

    // Randomised transfers.
    for (int r = 0; r < 25; r++) begin
      n = $urandom_range(0, 15);
      foreach (dl[i]) begin
        dl[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, Tmo - 1) : 0;
        if ($urandom_range(0, 24) == 0) dl[i] = Tmo;
      end
      ab = (n > 0 && $urandom_range(0, 5) == 0) ? $urandom_range(0, n - 1) : -1;
      run_xfer(1'($urandom_range(0, 1)), 8'($urandom), 6'($urandom), n, ab);
    end

    // Reset mid-transfer with abort/ack asserted.
    run_xfer(1'b1, 8'h77, 6'h0b, 0, -1);
    bus.start = 1; bus.dir = 1; bus.base_sdram = 8'h88; bus.base_mem = 6'h0c;
    bus.num_bursts = 4'd5;
    step();
    bus.start = 0;
    repeat (6) step();
    chk("busy_before_rst", 32'(bus.busy), 32'd1);
    rst_n = 1'b0; bus.abort = 1; bus.sdram_rd_ack = 1;
    step();
    chk("rst_mid_outputs", 32'(obs_vec), 32'd0);
    chk("rst_mid_latch", 32'({bus.latch_sdram_addr, bus.latch_mem_addr}), 32'd0);
    chk("rst_mid_tmo", 32'(bus.timeout_err), 32'd0);
    rst_n = 1'b1; bus.abort = 0; bus.sdram_rd_ack = 0;
    step();
    chk("post_rst_idle", 32'(obs_vec), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
